prio_event_encoder: RTL and testbench

PRIO_EVENT_ENCODER -- requirements
Module: prio_event_encoder

---
 rtl/prio_event_encoder.sv | 76 +++++++
 tb/tb_prio_event_encoder.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prio_event_encoder.sv
// prio_event_encoder: pending-event register with fixed or round-robin priority encode
// and a valid/ready output stage.
module prio_event_encoder #(
   parameter int WIDTH   = 8,
   parameter int RR_MODE = 0,
   localparam int IDXW   = $clog2(WIDTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  req_in,
   input  logic              flush,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [IDXW-1:0]   out_idx,
   output logic [WIDTH-1:0]  pending,
   output logic [IDXW:0]     pend_cnt,
   output logic              merged
);

   logic [IDXW-1:0]  rr_ptr, start_n, sel, j;
   logic [WIDTH-1:0] served, pnext;
   logic             xfer, load, found;

   always_comb begin
      xfer    = out_valid & out_ready;
      served  = xfer ? WIDTH'(1) << out_idx : '0;
      pnext   = (pending & ~served) | req_in;
      load    = ~out_valid | xfer;
      // Search start: fixed mode always from the top; RR restarts just below the last grant.
      start_n = RR_MODE == 0 ? IDXW'(WIDTH - 1) :
                !xfer ? rr_ptr :
                out_idx == '0 ? IDXW'(WIDTH - 1) : out_idx - IDXW'(1);
   end

   always_comb begin
      sel   = '0;
      found = 1'b0;
      j     = '0;
      for (int i = 0; i < WIDTH; i++) begin
         j = IDXW'((int'(start_n) + WIDTH - i) % WIDTH);
         if (!found && pnext[j]) begin
            found = 1'b1;
            sel   = j;
         end
      end
   end

   always_comb begin
      pend_cnt = '0;
      for (int i = 0; i < WIDTH; i++) pend_cnt = pend_cnt + (IDXW+1)'(pending[i]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         merged    <= 1'b0;
         rr_ptr    <= IDXW'(WIDTH - 1);
      end else if (flush) begin
         pending   <= '0;
         out_valid <= 1'b0;
         out_idx   <= '0;
         merged    <= 1'b0;
      end else begin
         pending <= pnext;
         merged  <= |(req_in & pending & ~served);
         rr_ptr  <= start_n;
         if (load) begin
            out_valid <= |pnext;
            out_idx   <= sel;
         end
      end
   end

endmodule

// File: tb/tb_prio_event_encoder.sv
// tb_prio_event_encoder: directed and random checks of fixed (u0) and round-robin (u1)
// instances against a cycle-level behavioural model.
module tb_prio_event_encoder;

   logic       clk = 1'b0, rst_n = 1'b0, flush = 1'b0, ready = 1'b0;
   logic [7:0] req = '0;
   logic       v_o[2], mg_o[2];
   logic [2:0] idx_o[2];
   logic [7:0] pend_o[2];
   logic [3:0] cnt_o[2];

   logic [7:0] m_pend[2];
   logic       m_valid[2], m_merged[2];
   int         m_idx[2], m_ptr[2];
   int         total = 0, passed = 0;
   int         rr_exp[6] = '{7, 1, 0, 7, 1, 0};

   prio_event_encoder #(.WIDTH(8), .RR_MODE(0)) u0 (
      .clk(clk), .rst_n(rst_n), .req_in(req), .flush(flush), .out_ready(ready),
      .out_valid(v_o[0]), .out_idx(idx_o[0]), .pending(pend_o[0]),
      .pend_cnt(cnt_o[0]), .merged(mg_o[0]));

   prio_event_encoder #(.WIDTH(8), .RR_MODE(1)) u1 (
      .clk(clk), .rst_n(rst_n), .req_in(req), .flush(flush), .out_ready(ready),
      .out_valid(v_o[1]), .out_idx(idx_o[1]), .pending(pend_o[1]),
      .pend_cnt(cnt_o[1]), .merged(mg_o[1]));

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      total++;
      assert (got === exp) passed++;
      else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = '0; m_valid[m] = 1'b0; m_merged[m] = 1'b0; m_idx[m] = 0; m_ptr[m] = 7;
      end
   endtask

   // first set bit walking downward from start, wrapping past 0 to 7
   function automatic int pick(logic [7:0] p, int start);
      for (int k = 0; k < 8; k++)
         if (p[(start - k + 8) % 8]) return (start - k + 8) % 8;
      return 0;
   endfunction

   task automatic check_all();
      for (int m = 0; m < 2; m++) begin
         chk($sformatf("m%0d_valid", m), 32'(v_o[m]), 32'(m_valid[m]));
         chk($sformatf("m%0d_idx", m), 32'(idx_o[m]), 32'(m_idx[m]));
         chk($sformatf("m%0d_pend", m), 32'(pend_o[m]), 32'(m_pend[m]));
         chk($sformatf("m%0d_cnt", m), 32'(cnt_o[m]), 32'($countones(m_pend[m])));
         chk($sformatf("m%0d_merged", m), 32'(mg_o[m]), 32'(m_merged[m]));
      end
   endtask

   task automatic cycle();
      logic [7:0] np[2];
      logic       nv[2], nm[2];
      int         ni[2], nptr[2];
      for (int m = 0; m < 2; m++) begin
         logic       xf;
         logic [7:0] pn;
         xf = m_valid[m] && ready;
         pn = m_pend[m];
         if (xf) pn[m_idx[m]] = 1'b0;
         nm[m] = |(req & pn);
         pn = pn | req;
         nv[m] = m_valid[m]; ni[m] = m_idx[m]; nptr[m] = m_ptr[m]; np[m] = pn;
         if (flush) begin
            np[m] = '0; nv[m] = 1'b0; ni[m] = 0; nm[m] = 1'b0;
         end else begin
            if (m == 1 && xf) nptr[m] = (m_idx[m] + 7) % 8;
            if (!m_valid[m] || xf) begin
               nv[m] = pn != 0;
               ni[m] = pick(pn, m == 1 ? nptr[m] : 7);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
         m_pend[m] = np[m]; m_valid[m] = nv[m]; m_idx[m] = ni[m];
         m_merged[m] = nm[m]; m_ptr[m] = nptr[m];
      end
      check_all();
   endtask

   initial begin
      model_reset();
      #2 check_all();
      @(negedge clk) rst_n = 1'b1;

      // fixed priority drain of three events
      req = 8'b0010_1001; ready = 1'b1;
      cycle(); req = '0;
      chk("r31_idx5", 32'(idx_o[0]), 5); chk("r31_cnt3", 32'(cnt_o[0]), 3);
      cycle();
      chk("r31_idx3", 32'(idx_o[0]), 3); chk("r31_cnt2", 32'(cnt_o[0]), 2);
      cycle();
      chk("r31_idx0", 32'(idx_o[0]), 0); chk("r31_cnt1", 32'(cnt_o[0]), 1);
      cycle();
      chk("r31_idle", 32'(v_o[0]), 0); chk("r31_cnt0", 32'(cnt_o[0]), 0);

      // stalled output holds its index
      ready = 1'b0; req = 8'h01;
      cycle(); req = 8'h80;
      chk("r32_hold_a", 32'(idx_o[0]), 0);
      cycle(); req = '0;
      chk("r32_hold_b", 32'(idx_o[0]), 0); chk("r32_pend", 32'(pend_o[0]), 32'h81);
      ready = 1'b1;
      cycle();
      chk("r32_next7", 32'(idx_o[0]), 7);
      cycle();
      chk("r32_done", 32'(v_o[0]), 0);

      // async reset between edges with events pending
      ready = 1'b0; req = 8'h12;
      cycle(); req = '0;
      chk("r36_pre", 32'(pend_o[0]), 32'h12);
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk) rst_n = 1'b1;
      ready = 1'b1;
      cycle();
      chk("r30_idle", 32'(v_o[1]), 0);

      // round-robin with a held request pattern
      req = 8'b1000_0011;
      for (int k = 0; k < 6; k++) begin
         cycle();
         chk($sformatf("r33_grant%0d", k), 32'(idx_o[1]), 32'(rr_exp[k]));
      end
      req = '0; flush = 1'b1;
      cycle(); flush = 1'b0;

      // repeated request on a pending bit merges
      ready = 1'b0; req = 8'h04;
      cycle();
      chk("r34_first", 32'(mg_o[0]), 0);
      cycle(); req = '0;
      chk("r34_merge", 32'(mg_o[0]), 1); chk("r34_cnt", 32'(cnt_o[0]), 1);
      cycle();
      chk("r34_pulse", 32'(mg_o[0]), 0);

      // flush beats a simultaneous transfer
      req = 8'hFF;
      cycle(); req = '0;
      chk("r35_full", 32'(cnt_o[0]), 8);
      flush = 1'b1; ready = 1'b1;
      cycle(); flush = 1'b0;
      chk("r35_pend", 32'(pend_o[0]), 0); chk("r35_valid", 32'(v_o[0]), 0);
      chk("r35_cnt", 32'(cnt_o[0]), 0);

      for (int n = 0; n < 500; n++) begin
         req   = 8'($urandom) & 8'($urandom);
         ready = $urandom_range(0, 3) != 0;
         flush = $urandom_range(0, 24) == 0;
         cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
